generador_pwm: RTL

Tick-driven PWM generator sitting directly downstream of the cycle counter: it consumes that counter's one-clock `flag` pulse as its time base (`tick`) and produces a PWM waveform whose period and high time are expressed in ticks. Period and duty inputs are captured into shadow registers only at period boundaries, so software-side changes never produce runt pulses. A small state machine completes the current period cleanly when the block is disabled.

---
 rtl/generador_pwm_pkg.sv | 12 +
 rtl/generador_pwm.sv | 103 ++++++++++
 2 files changed

// File: rtl/generador_pwm_pkg.sv
// rtl/generador_pwm_pkg.sv - shared state encoding and defaults for the tick-driven PWM generator
package generador_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } estado_t;

  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/generador_pwm.sv
// rtl/generador_pwm.sv - PWM generator timed by an upstream tick, with period-boundary shadowing
module generador_pwm
  import generador_pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic [WIDTH-1:0] periodo,
  input  logic [WIDTH-1:0] ciclo_trabajo,
  output logic             pwm,
  output logic             inicio_periodo,
  output logic             ocupado
);

  estado_t          estado, estado_sig;
  logic [WIDTH-1:0] cnt, per_sh, duty_sh;
  logic [WIDTH-1:0] cnt_sig, per_sig, duty_sig;
  logic             pwm_sig, inicio_sig;
  logic [WIDTH:0]   cnt_inc;
  logic             wrap;

  // One extra bit so the duty compare never sees cnt+1 wrap to zero.
  assign cnt_inc = {1'b0, cnt} + {{WIDTH{1'b0}}, 1'b1};
  assign wrap    = tick && (cnt == per_sh);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado         <= IDLE;
      cnt            <= '0;
      per_sh         <= '0;
      duty_sh        <= '0;
      pwm            <= 1'b0;
      inicio_periodo <= 1'b0;
    end else begin
      estado         <= estado_sig;
      cnt            <= cnt_sig;
      per_sh         <= per_sig;
      duty_sh        <= duty_sig;
      pwm            <= pwm_sig;
      inicio_periodo <= inicio_sig;
    end
  end

  // FINISH only differs from RUN at the wrap tick, so enable alone selects between them.
  always_comb begin
    estado_sig = IDLE;
    case (estado)
      IDLE:        estado_sig = (enable && tick) ? RUN : IDLE;
      RUN, FINISH: begin
        if (wrap && !enable) estado_sig = IDLE;
        else if (enable)     estado_sig = RUN;
        else                 estado_sig = FINISH;
      end
      default:     estado_sig = IDLE;
    endcase
  end

  always_comb begin
    cnt_sig    = cnt;
    per_sig    = per_sh;
    duty_sig   = duty_sh;
    pwm_sig    = pwm;
    inicio_sig = 1'b0;
    case (estado)
      IDLE: begin
        pwm_sig = 1'b0;
        if (enable && tick) begin
          cnt_sig    = '0;
          per_sig    = periodo;
          duty_sig   = ciclo_trabajo;
          inicio_sig = 1'b1;
          pwm_sig    = (ciclo_trabajo != '0);
        end
      end
      RUN, FINISH: begin
        if (wrap) begin
          cnt_sig = '0;
          if (enable) begin
            per_sig    = periodo;
            duty_sig   = ciclo_trabajo;
            inicio_sig = 1'b1;
            pwm_sig    = (ciclo_trabajo != '0);
          end else begin
            pwm_sig = 1'b0;
          end
        end else if (tick) begin
          cnt_sig = cnt_inc[WIDTH-1:0];
          pwm_sig = (cnt_inc < {1'b0, duty_sh});
        end
      end
      default: begin
        cnt_sig = '0;
        pwm_sig = 1'b0;
      end
    endcase
  end

  assign ocupado = (estado != IDLE);

endmodule
